// File: rtl/uart_io_pkg.sv
// uart_io_pkg: shared types and constants for the UART IO-register byte buffers.
//   txd_state_t    - TX drain FSM states
//   UART_DATA_BITS - byte width used by uart_lite
package uart_io_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        TXD_IDLE,
        TXD_SEND,
        TXD_WAIT_BUSY
    } txd_state_t;

endpackage : uart_io_pkg

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO.
//   clk, resetn - clock, async active-low reset
//   wr, din     - push strobe and data; accepted when not full, or when full with an accepted pop
//   rd          - pop strobe; ignored while empty
//   dout        - head entry, combinational (meaningless while empty)
//   full, empty - occupancy flags
//   level       - occupancy 0..DEPTH
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module sync_fifo_fwft #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr,
    input  logic [DW-1:0]            din,
    input  logic                     rd,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [PW-1:0] PtrOne  = PW'(1);
    localparam logic [LW-1:0] LvlOne  = LW'(1);
    localparam logic [LW-1:0] LvlFull = LW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full  = (level_q == LvlFull);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem[rd_ptr_q];

    // A pop frees the slot on the same edge, so full + push + pop both succeed.
    assign do_pop  = rd && !empty;
    assign do_push = wr && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LvlOne;
            2'b01:   level_d = level_q - LvlOne;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule : sync_fifo_fwft

// File: rtl/uart_io_fifo.sv
// uart_io_fifo: byte buffering between the CPU IO-register path and uart_lite.
//   clk, resetn                 - clock, async active-low reset
//   wr_vld, wr_data             - FW push into TX FIFO
//   tx_full, tx_level           - TX FIFO status
//   uart_tx_rdy                 - uart_lite ready for a byte
//   uart_tx_vld, uart_tx_data   - one-cycle launch pulse and byte to uart_lite
//   uart_rx_valid, uart_rx_data - byte received by uart_lite
//   rd_req                      - FW pop from RX FIFO
//   rd_vld, rd_data, rx_level   - RX FIFO status and FWFT head byte
//   ovf_clr                     - clear both sticky overflow flags
//   tx_ovf, rx_ovf              - sticky: a byte was dropped on a full FIFO
module uart_io_fifo
    import uart_io_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DATA_BITS = UART_DATA_BITS
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wr_vld,
    input  logic [DATA_BITS-1:0]         wr_data,
    output logic                         tx_full,
    output logic [$clog2(DEPTH):0]       tx_level,
    input  logic                         uart_tx_rdy,
    output logic                         uart_tx_vld,
    output logic [DATA_BITS-1:0]         uart_tx_data,
    input  logic                         uart_rx_valid,
    input  logic [DATA_BITS-1:0]         uart_rx_data,
    input  logic                         rd_req,
    output logic                         rd_vld,
    output logic [DATA_BITS-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]       rx_level,
    input  logic                         ovf_clr,
    output logic                         tx_ovf,
    output logic                         rx_ovf
);

    localparam int unsigned LVL_WL = $clog2(DEPTH) + 1;

    txd_state_t           state_q, state_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_empty, tx_pop;
    logic                 rx_full, rx_empty;
    logic                 tx_drop, rx_drop;
    logic                 tx_ovf_q, tx_ovf_d;
    logic                 rx_ovf_q, rx_ovf_d;
    logic [LVL_WL-1:0]    tx_level_w, rx_level_w;

    // ---------------- TX path ----------------
    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .DW    (DATA_BITS)
    ) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr     (wr_vld),
        .din    (wr_data),
        .rd     (tx_pop),
        .dout   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .level  (tx_level_w)
    );

    assign tx_level = tx_level_w;

    // Drain FSM. WAIT_BUSY holds off the next launch until uart_lite has
    // visibly dropped tx_rdy, so a late deassert cannot cause a double launch.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_pop    = 1'b0;
        unique case (state_q)
            TXD_IDLE: begin
                if (uart_tx_rdy && !tx_empty) begin
                    tx_pop    = 1'b1;
                    tx_data_d = tx_head;
                    state_d   = TXD_SEND;
                end
            end
            TXD_SEND: begin
                state_d = TXD_WAIT_BUSY;
            end
            TXD_WAIT_BUSY: begin
                if (!uart_tx_rdy) begin
                    state_d = TXD_IDLE;
                end
            end
            default: begin
                state_d = TXD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= TXD_IDLE;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Decoded straight from the state flop so reset drops it immediately.
    assign uart_tx_vld  = (state_q == TXD_SEND);
    assign uart_tx_data = tx_data_q;

    // ---------------- RX path ----------------
    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .DW    (DATA_BITS)
    ) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr     (uart_rx_valid),
        .din    (uart_rx_data),
        .rd     (rd_req),
        .dout   (rd_data),
        .full   (rx_full),
        .empty  (rx_empty),
        .level  (rx_level_w)
    );

    assign rd_vld   = !rx_empty;
    assign rx_level = rx_level_w;

    // ---------------- Sticky overflow flags ----------------
    // A push into a full FIFO only drops when no pop frees a slot that edge.
    // A full FIFO is never empty, so the raw pop strobe is enough here.
    assign tx_drop = wr_vld && tx_full && !tx_pop;
    assign rx_drop = uart_rx_valid && rx_full && !rd_req;

    // Set has priority over clear.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;
        if (ovf_clr) begin
            tx_ovf_d = 1'b0;
            rx_ovf_d = 1'b0;
        end
        if (tx_drop) begin
            tx_ovf_d = 1'b1;
        end
        if (rx_drop) begin
            rx_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
        end
    end

    assign tx_ovf = tx_ovf_q;
    assign rx_ovf = rx_ovf_q;

endmodule : uart_io_fifo

// File: tb/tb_uart_io_fifo.sv
// Directed self-checking bench for uart_io_fifo (DEPTH=16, DATA_BITS=8).
module tb_uart_io_fifo;

    logic       clk;
    logic       resetn;
    logic       wr_vld;
    logic [7:0] wr_data;
    logic       tx_full;
    logic [4:0] tx_level;
    logic       uart_tx_rdy;
    logic       uart_tx_vld;
    logic [7:0] uart_tx_data;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       rd_req;
    logic       rd_vld;
    logic [7:0] rd_data;
    logic [4:0] rx_level;
    logic       ovf_clr;
    logic       tx_ovf;
    logic       rx_ovf;

    int n_checks = 0;
    int n_errors = 0;

    uart_io_fifo #(
        .DEPTH     (16),
        .DATA_BITS (8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .wr_vld        (wr_vld),
        .wr_data       (wr_data),
        .tx_full       (tx_full),
        .tx_level      (tx_level),
        .uart_tx_rdy   (uart_tx_rdy),
        .uart_tx_vld   (uart_tx_vld),
        .uart_tx_data  (uart_tx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .rd_req        (rd_req),
        .rd_vld        (rd_vld),
        .rd_data       (rd_data),
        .rx_level      (rx_level),
        .ovf_clr       (ovf_clr),
        .tx_ovf        (tx_ovf),
        .rx_ovf        (rx_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_vld(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (uart_tx_vld) seen = 1'b1;
            else tick();
        end
    endtask

    // Stand-in for uart_lite taking one byte: ready, accept the pulse, go busy.
    task automatic send_one(input string tag, input logic [7:0] exp);
        bit seen;
        uart_tx_rdy = 1'b1;
        wait_tx_vld(20, seen);
        check_eq({tag, " vld"}, 32'(seen), 32'd1);
        if (seen) check_eq({tag, " data"}, 32'(uart_tx_data), 32'(exp));
        tick();
        check_eq({tag, " pulse"}, 32'(uart_tx_vld), 32'd0);
        uart_tx_rdy = 1'b0;
        tick();
    endtask

    task automatic push_tx(input logic [7:0] b);
        wr_vld  = 1'b1;
        wr_data = b;
        tick();
        wr_vld  = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        tick();
        uart_rx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  seen;

        resetn        = 1'b0;
        wr_vld        = 1'b0;
        wr_data       = '0;
        uart_tx_rdy   = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = '0;
        rd_req        = 1'b0;
        ovf_clr       = 1'b0;
        #2;
        check_eq("rst tx_level", 32'(tx_level), 32'd0);
        check_eq("rst rx_level", 32'(rx_level), 32'd0);
        check_eq("rst tx_vld",   32'(uart_tx_vld), 32'd0);
        check_eq("rst tx_full",  32'(tx_full), 32'd0);
        check_eq("rst rd_vld",   32'(rd_vld), 32'd0);
        check_eq("rst ovf",      32'({tx_ovf, rx_ovf}), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // 1: single byte latency
        uart_tx_rdy = 1'b1;
        push_tx(8'h41);
        check_eq("t1 level1", 32'(tx_level), 32'd1);
        check_eq("t1 vld early", 32'(uart_tx_vld), 32'd0);
        tick();
        check_eq("t1 vld", 32'(uart_tx_vld), 32'd1);
        check_eq("t1 data", 32'(uart_tx_data), 32'h41);
        check_eq("t1 level0", 32'(tx_level), 32'd0);
        tick();
        check_eq("t1 pulse", 32'(uart_tx_vld), 32'd0);
        uart_tx_rdy = 1'b0;
        tick();

        // 2: fill + overflow, then ordered drain
        for (int i = 0; i < 17; i++) push_tx(8'(i));
        check_eq("t2 full", 32'(tx_full), 32'd1);
        check_eq("t2 level", 32'(tx_level), 32'd16);
        check_eq("t2 ovf", 32'(tx_ovf), 32'd1);
        for (int i = 0; i < 16; i++) send_one($sformatf("t2 byte%0d", i), 8'(i));
        uart_tx_rdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (uart_tx_vld) cnt++;
            tick();
        end
        check_eq("t2 no extra", 32'(cnt), 32'd0);
        check_eq("t2 drained", 32'(tx_level), 32'd0);
        uart_tx_rdy = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("t2 ovf clr", 32'(tx_ovf), 32'd0);

        // 3: late tx_rdy deassert must not relaunch
        push_tx(8'h61);
        push_tx(8'h62);
        uart_tx_rdy = 1'b1;
        wait_tx_vld(20, seen);
        check_eq("t3 vld1", 32'(seen), 32'd1);
        check_eq("t3 data1", 32'(uart_tx_data), 32'h61);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (uart_tx_vld) cnt++;
        end
        check_eq("t3 hold", 32'(cnt), 32'd0);
        check_eq("t3 queued", 32'(tx_level), 32'd1);
        uart_tx_rdy = 1'b0;
        tick();
        send_one("t3 byte2", 8'h62);

        // 4: RX basic
        push_rx(8'hA5);
        check_eq("t4 rd_vld", 32'(rd_vld), 32'd1);
        push_rx(8'h5A);
        check_eq("t4 head", 32'(rd_data), 32'hA5);
        check_eq("t4 level2", 32'(rx_level), 32'd2);
        pop_rx();
        check_eq("t4 head2", 32'(rd_data), 32'h5A);
        check_eq("t4 level1", 32'(rx_level), 32'd1);
        pop_rx();
        pop_rx();
        check_eq("t4 empty lvl", 32'(rx_level), 32'd0);
        check_eq("t4 empty vld", 32'(rd_vld), 32'd0);
        check_eq("t4 no ovf", 32'(rx_ovf), 32'd0);

        // 5: RX full with simultaneous push/pop, then set-beats-clear
        for (int i = 0; i < 16; i++) push_rx(8'(8'h80 + i));
        check_eq("t5 full lvl", 32'(rx_level), 32'd16);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'hEE;
        rd_req        = 1'b1;
        tick();
        uart_rx_valid = 1'b0;
        rd_req        = 1'b0;
        check_eq("t5 lvl same", 32'(rx_level), 32'd16);
        check_eq("t5 no ovf", 32'(rx_ovf), 32'd0);
        check_eq("t5 head", 32'(rd_data), 32'h81);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h77;
        ovf_clr       = 1'b1;
        tick();
        uart_rx_valid = 1'b0;
        ovf_clr       = 1'b0;
        check_eq("t5 ovf set wins", 32'(rx_ovf), 32'd1);
        check_eq("t5 lvl kept", 32'(rx_level), 32'd16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("t5 ovf clr", 32'(rx_ovf), 32'd0);
        cnt = 0;
        for (int i = 1; i < 16; i++) begin
            if (rd_data !== 8'(8'h80 + i)) cnt++;
            pop_rx();
        end
        check_eq("t5 order errs", 32'(cnt), 32'd0);
        check_eq("t5 tail", 32'(rd_data), 32'hEE);
        check_eq("t5 tail lvl", 32'(rx_level), 32'd1);
        pop_rx();

        // 6: reset mid-drain
        push_rx(8'h11);
        push_rx(8'h22);
        for (int i = 0; i < 5; i++) push_tx(8'(8'hC0 + i));
        send_one("t6 byte0", 8'hC0);
        uart_tx_rdy = 1'b1;
        wait_tx_vld(20, seen);
        check_eq("t6 vld", 32'(seen), 32'd1);
        resetn = 1'b0;
        #1;
        check_eq("t6 vld drop", 32'(uart_tx_vld), 32'd0);
        check_eq("t6 tx_level", 32'(tx_level), 32'd0);
        check_eq("t6 rx_level", 32'(rx_level), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uart_tx_vld) cnt++;
        end
        check_eq("t6 no vld", 32'(cnt), 32'd0);
        check_eq("t6 rd_vld", 32'(rd_vld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_io_fifo
